// File: rtl/reset_sequencer.sv
// Reset sequencer: asserts NUM_DOMAINS resets together on any request, releases them in index order once the MMCM is locked.
// Latency: a trigger re-asserts every output on the next cycle; rstReqExt/mmcmLocked pass through a 2-flop synchroniser first.
// Backpressure: none; every request is accepted immediately, restarts the sequence and is logged in a sticky cause register.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int FILTER_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rstReqExt,
  input  logic                   mmcmLocked,
  input  logic                   softReq,
  input  logic                   causeClr,
  output logic [NUM_DOMAINS-1:0] rstOut,
  output logic                   allReleased,
  output logic [1:0]             state,
  output logic [3:0]             cause
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 stateQ, stateD;
  logic [1:0]             lockSync, reqSync;
  logic [FILTER_BITS-1:0] filterCnt;
  logic [HW-1:0]          holdCnt, holdD;
  logic [DW-1:0]          delayCnt, delayD;
  logic [IW-1:0]          idx, idxD;
  logic [NUM_DOMAINS-1:0] rstD;
  logic [3:0]             causeD;
  logic                   lockedS, reqS, extTrig, lockTrig, softTrig, trigAny, liveState;

  assign lockedS   = lockSync[1];
  assign reqS      = reqSync[1];
  assign liveState = (stateQ == RELEASE) || (stateQ == RUN);
  assign extTrig   = reqS & (&filterCnt);
  // WAIT_LOCK is the state that waits out a missing lock, so it must not re-trigger on it.
  assign lockTrig  = ~lockedS & liveState;
  assign softTrig  = softReq & liveState;
  assign trigAny   = extTrig | lockTrig | softTrig;
  assign state     = stateQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= ASSERT;
      lockSync    <= 2'b00;
      reqSync     <= 2'b00;
      filterCnt   <= '0;
      holdCnt     <= '0;
      delayCnt    <= '0;
      idx         <= '0;
      rstOut      <= '1;
      allReleased <= 1'b0;
      cause       <= 4'b0001;
    end else begin
      stateQ      <= stateD;
      lockSync    <= {lockSync[0], mmcmLocked};
      reqSync     <= {reqSync[0], rstReqExt};
      filterCnt   <= !reqS ? '0 : ((&filterCnt) ? filterCnt : filterCnt + 1'b1);
      holdCnt     <= holdD;
      delayCnt    <= delayD;
      idx         <= idxD;
      rstOut      <= rstD;
      allReleased <= (stateD == RUN);
      cause       <= causeD;
    end
  end

  always_comb begin
    stateD = stateQ;
    holdD  = holdCnt;
    delayD = delayCnt;
    idxD   = idx;
    rstD   = rstOut;
    // Set wins over clear so a request landing with causeClr is never lost.
    causeD = (causeClr ? 4'b0000 : cause) | {lockTrig, softTrig, extTrig, 1'b0};
    if (trigAny) begin
      stateD = ASSERT;
      holdD  = '0;
      delayD = '0;
      idxD   = '0;
      rstD   = '1;
    end else begin
      case (stateQ)
        ASSERT: begin
          if (softReq) begin
            holdD = '0;
          end else if (holdCnt == HOLD_LAST) begin
            stateD = WAIT_LOCK;
          end else begin
            holdD = holdCnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lockedS) begin
            stateD = RELEASE;
            delayD = '0;
            idxD   = '0;
          end
        end
        RELEASE: begin
          if (delayCnt == DELAY_LAST) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (idx == IW'(k)) rstD[k] = 1'b0;
            end
            delayD = '0;
            if (idx == IDX_LAST) begin
              stateD = RUN;
            end else begin
              idxD = idx + 1'b1;
            end
          end else begin
            delayD = delayCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios then random traffic, checked every cycle against a timeline model.
module tb_reset_sequencer;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int HC = 8;
  localparam int FB = 3;

  logic          clk = 1'b0;
  logic          rst, rstReqExt, mmcmLocked, softReq, causeClr;
  logic [ND-1:0] rstOut;
  logic          allReleased;
  logic [1:0]    state;
  logic [3:0]    cause;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  reset_sequencer #(.NUM_DOMAINS(ND), .STAGE_DELAY(SD), .HOLD_CYCLES(HC), .FILTER_BITS(FB)) dut (
    .clk(clk), .rst(rst), .rstReqExt(rstReqExt), .mmcmLocked(mmcmLocked),
    .softReq(softReq), .causeClr(causeClr), .rstOut(rstOut),
    .allReleased(allReleased), .state(state), .cause(cause)
  );

  always #5 clk = ~clk;

  // Model: phase number, cycles spent holding, cycles since release began, length of current request run.
  int       mSt, mHold, mRel, mRun;
  logic [3:0] mCause;
  logic     lockQ[$];
  logic     reqQ[$];

  function automatic logic [ND-1:0] mOut();
    logic [ND-1:0] v;
    for (int k = 0; k < ND; k++) begin
      if (mSt < 2)       v[k] = 1'b1;
      else if (mSt == 2) v[k] = (mRel < (k + 1) * SD);
      else               v[k] = 1'b0;
    end
    return v;
  endfunction

  task automatic modelStep();
    logic ext, lck, sft, live;
    if (rst) begin
      mSt = 0; mHold = 0; mRel = 0; mRun = 0; mCause = 4'b0001;
      lockQ = '{1'b0, 1'b0};
      reqQ  = '{1'b0, 1'b0};
      return;
    end
    live = (mSt == 2) || (mSt == 3);
    ext  = reqQ[0] && (mRun >= (1 << FB));
    lck  = !lockQ[0] && live;
    sft  = softReq && live;
    if (causeClr) mCause = 4'b0000;
    mCause = mCause | {lck, sft, ext, 1'b0};
    if (ext || lck || sft) begin
      mSt = 0; mHold = 0;
    end else if (mSt == 0) begin
      if (softReq)             mHold = 0;
      else if (mHold == HC - 1) mSt = 1;
      else                     mHold++;
    end else if (mSt == 1) begin
      if (lockQ[0]) begin mSt = 2; mRel = 0; end
    end else if (mSt == 2) begin
      mRel++;
      if (mRel == ND * SD) mSt = 3;
    end
    void'(lockQ.pop_front()); lockQ.push_back(mmcmLocked);
    void'(reqQ.pop_front());  reqQ.push_back(rstReqExt);
    mRun = reqQ[0] ? mRun + 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    chk("state", 8'(state), 8'(mSt));
    chk("rstOut", 8'(rstOut), 8'(mOut()));
    chk("allReleased", 8'(allReleased), 8'(mSt == 3));
    chk("cause", 8'(cause), 8'(mCause));
  endtask

  task automatic waitState(input int st, input int budget, input string tag);
    int n = 0;
    while (mSt != st && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $error("FAIL %s timeout: state %0d expected %0d", tag, mSt, st);
    end
  endtask

  task automatic waitOut(input logic [ND-1:0] target, input int budget, input string tag);
    int n = 0;
    while (mOut() !== target && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $error("FAIL %s timeout: rstOut %0h expected %0h", tag, mOut(), target);
    end
  endtask

  task automatic pulseSoft();
    softReq = 1'b1; tick(); softReq = 1'b0;
  endtask

  initial begin
    int extLeft, lockLeft;
    rst = 1'b1; rstReqExt = 1'b0; mmcmLocked = 1'b1; softReq = 1'b0; causeClr = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_rstOut", 8'(rstOut), 8'h07);
    chk("reset_allReleased", 8'(allReleased), 8'd0);
    chk("reset_cause", 8'(cause), 8'h01);

    // 1: power-on release timeline
    rst = 1'b0; cyc = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 7)  chk("s1_assert_c7", 8'(state), 8'd0);
      if (c == 8)  chk("s1_wait_c8", 8'(state), 8'd1);
      if (c == 9)  chk("s1_release_c9", 8'(state), 8'd2);
      if (c == 12) chk("s1_out_c12", 8'(rstOut), 8'h07);
      if (c == 13) chk("s1_out_c13", 8'(rstOut), 8'h06);
      if (c == 17) chk("s1_out_c17", 8'(rstOut), 8'h04);
      if (c == 20) chk("s1_allrel_c20", 8'(allReleased), 8'd0);
      if (c == 21) chk("s1_out_c21", 8'(rstOut), 8'h00);
      if (c == 21) chk("s1_allrel_c21", 8'(allReleased), 8'd1);
    end

    // 2: short press ignored, long press restarts
    rstReqExt = 1'b1; repeat (5) tick();
    rstReqExt = 1'b0; repeat (8) tick();
    chk("s2_short_ignored", 8'(rstOut), 8'h00);
    rstReqExt = 1'b1; repeat (20) tick();
    chk("s2_long_asserted", 8'(rstOut), 8'h07);
    rstReqExt = 1'b0;
    waitState(3, 200, "s2_rerun");
    chk("s2_cause", 8'(cause), 8'h03);

    // 3: lock loss holds in WAIT_LOCK until lock returns
    mmcmLocked = 1'b0; repeat (3) tick();
    chk("s3_lock_assert", 8'(rstOut), 8'h07);
    repeat (15) tick();
    chk("s3_wait_lock", 8'(state), 8'd1);
    chk("s3_cause", 8'(cause), 8'h0b);
    mmcmLocked = 1'b1;
    waitState(3, 200, "s3_rerun");

    // 4: soft request from RUN, from RELEASE and during ASSERT
    pulseSoft();
    waitOut(3'b110, 200, "s4_first_release");
    pulseSoft();
    chk("s4_soft_reassert", 8'(rstOut), 8'h07);
    repeat (3) tick();
    pulseSoft();
    chk("s4_cause_kept", 8'(cause), 8'h0f);
    waitState(3, 200, "s4_rerun");

    // 5: clear racing a lock trigger, then a plain clear
    mmcmLocked = 1'b0; tick(); tick();
    causeClr = 1'b1; tick(); causeClr = 1'b0;
    chk("s5_clear_with_trig", 8'(cause), 8'h08);
    mmcmLocked = 1'b1;
    waitState(3, 200, "s5_rerun");
    causeClr = 1'b1; tick(); causeClr = 1'b0;
    chk("s5_clear_alone", 8'(cause), 8'h00);

    // 6: rst mid-release
    pulseSoft();
    waitOut(3'b100, 200, "s6_partial");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_rstOut", 8'(rstOut), 8'h07);
    chk("s6_state", 8'(state), 8'd0);
    chk("s6_cause", 8'(cause), 8'h01);
    waitState(3, 200, "s6_rerun");

    // Random traffic: bursty button presses and lock drops, sparse soft/clear/rst.
    extLeft = 0; lockLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (extLeft == 0 && $urandom_range(0, 99) == 0)  extLeft = $urandom_range(1, 20);
      if (lockLeft == 0 && $urandom_range(0, 149) == 0) lockLeft = $urandom_range(1, 30);
      rstReqExt  = (extLeft > 0);
      mmcmLocked = (lockLeft == 0);
      if (extLeft > 0)  extLeft--;
      if (lockLeft > 0) lockLeft--;
      softReq  = ($urandom_range(0, 59) == 0);
      causeClr = ($urandom_range(0, 79) == 0);
      rst      = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; softReq = 1'b0; causeClr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
